led_blink_sequencer: RTL and testbench

//  Shares one active-low front-panel LED between NUM_SRC activity sources.

---
 rtl/led_blink_sequencer_if.sv | 30 +++
 rtl/led_blink_sequencer.sv | 163 ++++++++++++++++
 tb/tb_led_blink_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_blink_sequencer_if.sv
// Bundle for the shared-LED blink sequencer: per-source activity in, LED drive and grant status out.
// The sequencer connects through the slave modport; the stimulus/owner side uses master.
interface led_blink_sequencer_if #(
  parameter int NUM_SRC = 4
);
  logic               enable;
  logic [NUM_SRC-1:0] src_event;
  logic               led;
  logic               busy;
  logic [2:0]         active_src;
  logic               grant_stb;

  modport master (
    output enable,
    output src_event,
    input  led,
    input  busy,
    input  active_src,
    input  grant_stb
  );

  modport slave (
    input  enable,
    input  src_event,
    output led,
    output busy,
    output active_src,
    output grant_stb
  );
endinterface

// File: rtl/led_blink_sequencer.sv
// Shares one active-low LED between NUM_SRC sources: latched pending events, round-robin grant,
// and a blink code of (index+1) blinks followed by a gap for the granted source.
module led_blink_sequencer #(
  parameter int          NUM_SRC   = 4,
  parameter logic [24:0] ON_TICKS  = 25'd6_250_000,
  parameter logic [24:0] OFF_TICKS = 25'd6_250_000,
  parameter logic [24:0] GAP_TICKS = 25'd25_000_000
) (
  input logic                 clk,
  input logic                 rst,
  led_blink_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [2:0]         LAST_SRC  = 3'(NUM_SRC - 1);
  localparam logic [NUM_SRC-1:0] SRC0_MASK = {{(NUM_SRC-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [24:0]        tick_r;
  logic [2:0]         blinks_r;
  logic [NUM_SRC-1:0] pending_r;
  logic               led_r;
  logic               busy_r;
  logic [2:0]         active_src_r;
  logic               grant_stb_r;

  logic [3:0]         pick_s;
  logic               grant_s;
  logic [NUM_SRC-1:0] clr_s;

  // Round-robin pick: scan from last+1 upward with wrap; bit 3 flags a valid winner.
  // Iterating from the far end down lets the nearest pending source overwrite the result.
  function automatic logic [3:0] rr_pick(input logic [NUM_SRC-1:0] req, input logic [2:0] last);
    logic [3:0]         pick;
    logic [NUM_SRC-1:0] sh;
    int                 idx;
    pick = 4'b0000;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_SRC;
      sh  = req >> idx;
      if (sh[0]) begin
        pick = {1'b1, 3'(idx)};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Arbiter decision and the pending-clear mask for the grant cycle.
  always_comb begin
    pick_s  = rr_pick(pending_r, active_src_r);
    grant_s = 1'b0;
    clr_s   = {NUM_SRC{1'b0}};
    if ((state_r == ST_IDLE) && bus.enable && pick_s[3]) begin
      grant_s = 1'b1;
      clr_s   = SRC0_MASK << pick_s[2:0];
    end else begin
      grant_s = 1'b0;
      clr_s   = {NUM_SRC{1'b0}};
    end
  end

  // Pending latch; a new event on the grant cycle wins over the clear so the source is re-served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {NUM_SRC{1'b0}};
    end else if (!bus.enable) begin
      pending_r <= {NUM_SRC{1'b0}};
    end else begin
      pending_r <= (pending_r & ~clr_s) | bus.src_event;
    end
  end

  // Blink-code state machine with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      tick_r       <= 25'd0;
      blinks_r     <= 3'd0;
      led_r        <= 1'b1;
      busy_r       <= 1'b0;
      active_src_r <= LAST_SRC;
      grant_stb_r  <= 1'b0;
    end else begin
      grant_stb_r <= 1'b0;
      if (!bus.enable) begin
        state_r  <= ST_IDLE;
        tick_r   <= 25'd0;
        blinks_r <= 3'd0;
        led_r    <= 1'b1;
        busy_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            led_r  <= 1'b1;
            busy_r <= 1'b0;
            if (grant_s) begin
              state_r      <= ST_ON;
              led_r        <= 1'b0;
              busy_r       <= 1'b1;
              grant_stb_r  <= 1'b1;
              active_src_r <= pick_s[2:0];
              blinks_r     <= pick_s[2:0];
              tick_r       <= 25'd0;
            end
          end
          ST_ON: begin
            if (tick_r == ON_TICKS - 25'd1) begin
              tick_r  <= 25'd0;
              led_r   <= 1'b1;
              state_r <= ST_OFF;
            end else begin
              tick_r <= tick_r + 25'd1;
            end
          end
          ST_OFF: begin
            if (tick_r == OFF_TICKS - 25'd1) begin
              tick_r <= 25'd0;
              if (blinks_r != 3'd0) begin
                blinks_r <= blinks_r - 3'd1;
                state_r  <= ST_ON;
                led_r    <= 1'b0;
              end else begin
                state_r <= ST_GAP;
              end
            end else begin
              tick_r <= tick_r + 25'd1;
            end
          end
          ST_GAP: begin
            if (tick_r == GAP_TICKS - 25'd1) begin
              tick_r  <= 25'd0;
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              tick_r <= tick_r + 25'd1;
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            tick_r   <= 25'd0;
            blinks_r <= 3'd0;
            led_r    <= 1'b1;
            busy_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.led        = led_r;
  assign bus.busy       = busy_r;
  assign bus.active_src = active_src_r;
  assign bus.grant_stb  = grant_stb_r;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Self-checking bench for led_blink_sequencer: a directed vector table, hand-written corner
// sequences and randomized traffic checked against a waveform-queue reference model.
module tb_led_blink_sequencer;
  localparam int N   = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int GAP = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_blink_sequencer_if #(.NUM_SRC(N)) bus ();

  led_blink_sequencer #(
    .NUM_SRC  (N),
    .ON_TICKS (25'd3),
    .OFF_TICKS(25'd2),
    .GAP_TICKS(25'd5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: a code is a precomputed list of {led,busy} slots ending with one idle slot.
  typedef struct packed {logic led; logic busy;} slot_t;
  slot_t    q[$];
  bit [3:0] m_pend;
  int       m_last;
  bit       exp_led, exp_busy, exp_stb;

  int checks = 0;
  int failures = 0;
  int gq[$];

  typedef struct {
    bit       en;
    bit [3:0] ev;
    bit       led;
    bit       busy;
    bit       stb;
    int       src;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend   = 4'b0000;
    m_last   = N - 1;
    exp_led  = 1'b1;
    exp_busy = 1'b0;
    exp_stb  = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit [3:0] ev);
    bit [3:0] clr;
    bit [3:0] sh;
    int       w;
    slot_t    s;
    clr     = 4'b0000;
    exp_stb = 1'b0;
    if (!en) begin
      q.delete();
      m_pend   = 4'b0000;
      exp_led  = 1'b1;
      exp_busy = 1'b0;
      return;
    end
    if (q.size() == 0 && m_pend != 4'b0000) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        sh = m_pend >> ((m_last + k) % N);
        if (w < 0 && sh[0]) w = (m_last + k) % N;
      end
      m_last  = w;
      clr     = 4'b0001 << w;
      exp_stb = 1'b1;
      for (int b = 0; b <= w; b++) begin
        repeat (ON) q.push_back(2'b01);
        repeat (OFF) q.push_back(2'b11);
      end
      repeat (GAP) q.push_back(2'b11);
      q.push_back(2'b10);
    end
    m_pend = (m_pend & ~clr) | ev;
    if (q.size() != 0) begin
      s        = q.pop_front();
      exp_led  = s.led;
      exp_busy = s.busy;
    end else begin
      exp_led  = 1'b1;
      exp_busy = 1'b0;
    end
  endtask

  task automatic step(input bit en, input bit [3:0] ev);
    bus.enable    = en;
    bus.src_event = ev;
    @(posedge clk);
    model_edge(en, ev);
    #1;
    if (bus.grant_stb) gq.push_back(int'(bus.active_src));
    check("led", int'(bus.led), int'(exp_led));
    check("busy", int'(bus.busy), int'(exp_busy));
    check("grant_stb", int'(bus.grant_stb), int'(exp_stb));
    check("active_src", int'(bus.active_src), m_last);
  endtask

  task automatic add(input bit en, input bit [3:0] ev, input bit led, input bit busy,
                     input bit stb, input int src);
    vec_t v;
    v.en = en; v.ev = ev; v.led = led; v.busy = busy; v.stb = stb; v.src = src;
    vt.push_back(v);
  endtask

  initial begin
    bit [3:0] rev;
    bit       ren;
    int       n1;

    // Directed table: single pulse on src2 right after reset (3 blinks, busy 20 clocks).
    add(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 3);
    for (int b = 0; b < 3; b++) begin
      for (int t = 0; t < ON; t++) add(1'b1, 4'b0000, 1'b0, 1'b1, (b == 0 && t == 0), 2);
      for (int t = 0; t < OFF; t++) add(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2);
    end
    for (int t = 0; t < GAP; t++) add(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2);

    rst = 1'b1;
    bus.enable = 1'b0;
    bus.src_event = 4'b0000;
    model_reset();
    #12;
    check("reset_led", int'(bus.led), 1);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_stb", int'(bus.grant_stb), 0);
    check("reset_src", int'(bus.active_src), 3);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].en, vt[i].ev);
      check("tbl_led", int'(bus.led), int'(vt[i].led));
      check("tbl_busy", int'(bus.busy), int'(vt[i].busy));
      check("tbl_stb", int'(bus.grant_stb), int'(vt[i].stb));
      check("tbl_src", int'(bus.active_src), vt[i].src);
    end

    // T1: asynchronous reset in the first ON cycle of a src0 code.
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0000);
    check("t1_pre_led", int'(bus.led), 0);
    #3 rst = 1'b1;
    #1;
    check("t1_rst_led", int'(bus.led), 1);
    check("t1_rst_busy", int'(bus.busy), 0);
    check("t1_rst_stb", int'(bus.grant_stb), 0);
    check("t1_rst_src", int'(bus.active_src), 3);
    model_reset();
    #2 rst = 1'b0;
    repeat (6) step(1'b1, 4'b0000);

    // T3: src0 and src3 together -> src0 first, then src3.
    gq.delete();
    step(1'b1, 4'b1001);
    repeat (45) step(1'b1, 4'b0000);
    check("t3_count", gq.size(), 2);
    check("t3_first", (gq.size() > 0) ? gq[0] : -1, 0);
    check("t3_second", (gq.size() > 1) ? gq[1] : -1, 3);

    // T4: src1 held, src2 pulsed once -> 1,2,1,1.
    gq.delete();
    step(1'b1, 4'b0110);
    repeat (89) step(1'b1, 4'b0010);
    repeat (60) step(1'b1, 4'b0000);
    check("t4_g0", (gq.size() > 0) ? gq[0] : -1, 1);
    check("t4_g1", (gq.size() > 1) ? gq[1] : -1, 2);
    check("t4_g2", (gq.size() > 2) ? gq[2] : -1, 1);
    check("t4_g3", (gq.size() > 3) ? gq[3] : -1, 1);

    // T5: abort during the second blink of src3.
    gq.delete();
    step(1'b1, 4'b1000);
    repeat (6) step(1'b1, 4'b0000);
    check("t5_blink2_led", int'(bus.led), 0);
    step(1'b0, 4'b1111);
    check("t5_abort_led", int'(bus.led), 1);
    check("t5_abort_busy", int'(bus.busy), 0);
    repeat (12) step(1'b1, 4'b0000);
    check("t5_grants", gq.size(), 1);

    // T6: src1 re-triggered during its own gap -> exactly one more src1 code.
    gq.delete();
    step(1'b1, 4'b0010);
    repeat (11) step(1'b1, 4'b0000);
    check("t6_in_gap_busy", int'(bus.busy), 1);
    step(1'b1, 4'b0010);
    repeat (50) step(1'b1, 4'b0000);
    n1 = 0;
    foreach (gq[i]) if (gq[i] == 1) n1++;
    check("t6_grants", gq.size(), 2);
    check("t6_src1_codes", n1, 2);

    // Randomized traffic against the reference model.
    repeat (800) begin
      ren = ($urandom_range(0, 29) != 0);
      for (int b = 0; b < N; b++) rev[b] = ($urandom_range(0, 9) == 0);
      step(ren, rev);
    end
    repeat (150) step(1'b1, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
